keypad_scanner: RTL and testbench
=================================

Name: keypad_scanner

Overview:
Scans the 4x5 matrix keypad on the Nexys 4 Pmod header and debounces it. Produces the keycode/newKey pair consumed by CalculatorLogic: one newKey pulse per physical key press, with keycode stable around the pulse. It sits between the board pins and the calculator datapath and is the sole sequencer of calculator input.

Parameters:
SCAN_DIV, 5000, clocks each row is driven before its columns are sampled (1 ms at 5 MHz); legal minimum 4.
DEBOUNCE_SCANS, 8, consecutive identical full scans required to accept a press or a release; legal range 1..255.

Ports:
clock  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-low reset.
row  out  4  keypad row drive, active-low one-hot.
col  in  5  keypad column sense, active-low, asynchronous to clock.
newKey  out  1  one-clock pulse: a new debounced key is accepted.
keycode  out  5  accepted key code; 5'h00 when no key is held.
keyHeld  out  1  high from acceptance until the release is debounced.

Behaviour:
- Key map (row r, col c):
  - c=0..3 gives hex digit 4r+c, keycode = {1'b1, digit} (5'h10..5'h1F).
  - c=4 gives a control key: r0 CLEAR 5'h01, r1 PLUS 5'h02, r2 MUL 5'h03, r3 EQUAL 5'h04.
- Reset (reset low, asynchronous): row=4'b1110, newKey=0, keycode=5'h00, keyHeld=0, all counters 0, state IDLE.
- col passes through a 2-flop synchronizer before use.
- Scan:
  - Row index 0..3 advances every SCAN_DIV clocks and wraps 3 to 0.
  - The synchronized columns are sampled on the last clock of each row dwell.
  - One full scan = 4*SCAN_DIV clocks.
  - At scan end the result is one of: NONE (no column low), ONE(code) (exactly one key in the whole scan), or MULTI (two or more keys).
- FSM, evaluated only at scan end:
  - IDLE: ONE(code) -> latch candidate=code, cnt=1, go to DB_PRESS. Otherwise stay.
  - DB_PRESS:
    - ONE(same code) -> cnt++. When cnt reaches DEBOUNCE_SCANS, go to PRESSED.
    - ONE(different code) -> reload candidate, cnt=1.
    - NONE or MULTI -> IDLE.
  - PRESSED:
    - On entry: keycode<=candidate on that clock, newKey=1 on the following clock only, keyHeld=1.
    - NONE -> cnt=1, go to DB_RELEASE.
    - ONE or MULTI -> stay (a held key never repeats; a second key pressed while holding is ignored).
  - DB_RELEASE:
    - NONE -> cnt++. When cnt reaches DEBOUNCE_SCANS: keycode<=5'h00, keyHeld=0, go to IDLE.
    - Anything else -> PRESSED, with no new pulse.
- Latency:
  - Press stable from scan start to newKey: DEBOUNCE_SCANS full scans + 1 clock (plus synchronizer and partial-scan alignment).
  - keycode is valid at least 1 clock before newKey and stays valid for the whole pulse.
- DEBOUNCE_SCANS=1: a press is accepted on the first ONE scan.
- Reset mid-press: returns to IDLE. A key still held after reset deasserts is treated as a new press.

Decomposition:
- Package calc_keys_pkg: keycode constants (KEY_NULL, KEY_CLEAR, KEY_PLUS, KEY_MUL, KEY_EQUAL, DIGIT_FLAG=5'h10) and the FSM state enum. CalculatorLogic and the testbenches share it.
- Sub-module keypad_sync: parameterised-width 2-flop synchronizer with the same async active-low reset, used for col.

Test Plan (SCAN_DIV=4, DEBOUNCE_SCANS=3; full scan = 16 clocks):
1. Hold digit 7 (r1,c3) steady for 100 clocks -> exactly one newKey, keycode=5'h17 at the pulse, keyHeld=1. Release -> keyHeld=0 and keycode=5'h00 after 3 NONE scans.
2. Hold EQUAL (r3,c4) but release it for one scan after the first 2 scans -> no newKey. Then hold steady for 3 scans -> one newKey, keycode=5'h04.
3. Press 1, release, press 2, release, press PLUS -> newKey pulses with keycodes 5'h11, 5'h12, 5'h02 in order. No pulses during any hold.
4. Hold A and B (r2,c2 + r2,c3) together -> no newKey. Drop B -> one newKey, keycode=5'h1A.
5. Hold C, then add F while C is held, then release both -> only one newKey (5'h1C). Bounce C for 1 scan during DB_RELEASE -> no second pulse.
6. Assert reset mid DB_PRESS while holding 5 -> all outputs at reset values immediately, row=4'b1110. After reset deasserts, a new press of 5 is accepted after 3 scans, keycode=5'h15.

Source files
------------

// File: rtl/calc_keys_pkg.sv
// calc_keys_pkg: keycodes shared by the keypad scanner, CalculatorLogic and
// the benches, plus the scanner FSM state and per-scan result encodings.
//   key_code(r, c) maps a matrix position to its keycode.
package calc_keys_pkg;

  localparam logic [4:0] KEY_NULL   = 5'h00;
  localparam logic [4:0] KEY_CLEAR  = 5'h01;
  localparam logic [4:0] KEY_PLUS   = 5'h02;
  localparam logic [4:0] KEY_MUL    = 5'h03;
  localparam logic [4:0] KEY_EQUAL  = 5'h04;
  localparam logic [4:0] DIGIT_FLAG = 5'h10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DB_PRESS,
    ST_PRESSED,
    ST_DB_RELEASE
  } scan_state_t;

  typedef enum logic [1:0] {
    SCAN_NONE,
    SCAN_ONE,
    SCAN_MULTI
  } scan_result_t;

  // Columns 0..3 are hex digits 4r+c; column 4 holds the control keys.
  function automatic logic [4:0] key_code(input logic [1:0] r, input logic [2:0] c);
    logic [4:0] code;
    if (c == 3'd4) begin
      case (r)
        2'd0:    code = KEY_CLEAR;
        2'd1:    code = KEY_PLUS;
        2'd2:    code = KEY_MUL;
        default: code = KEY_EQUAL;
      endcase
    end else begin
      code = DIGIT_FLAG | {1'b0, r, c[1:0]};
    end
    return code;
  endfunction

endpackage

// File: rtl/keypad_sync.sv
// keypad_sync: per-bit two-flop synchronizer for asynchronous inputs.
//   clock     system clock
//   reset     asynchronous active-low reset, both stages load RESET_VAL
//   d         asynchronous input bus
//   q         synchronized output bus
module keypad_sync #(
  parameter int              WIDTH     = 5,
  parameter logic [WIDTH-1:0] RESET_VAL = '1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
      logic meta_reg;
      logic sync_reg;

      always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
          meta_reg <= RESET_VAL[gi];
          sync_reg <= RESET_VAL[gi];
        end else begin
          meta_reg <= d[gi];
          sync_reg <= meta_reg;
        end
      end

      assign q[gi] = sync_reg;
    end
  endgenerate

endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: scans and debounces a 4x5 active-low matrix keypad.
//   clock     system clock, rising edge
//   reset     asynchronous active-low reset
//   row       row drive, active-low one-hot
//   col       column sense, active-low, asynchronous
//   newKey    one-clock pulse per accepted press
//   keycode   accepted key code, KEY_NULL when no key is held
//   keyHeld   high from acceptance until the release is debounced
module keypad_scanner
  import calc_keys_pkg::*;
#(
  parameter int SCAN_DIV       = 5000,
  parameter int DEBOUNCE_SCANS = 8
) (
  input  logic       clock,
  input  logic       reset,
  output logic [3:0] row,
  input  logic [4:0] col,
  output logic       newKey,
  output logic [4:0] keycode,
  output logic       keyHeld
);

  localparam int              DIV_W     = $clog2(SCAN_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(SCAN_DIV - 1);
  localparam logic [7:0]       DB_TARGET = 8'(DEBOUNCE_SCANS);

  logic [4:0]       col_sync;
  logic [DIV_W-1:0] div_cnt_reg;
  logic [1:0]       row_idx_reg;
  logic [3:0]       row_reg;
  logic [1:0]       hit_cnt_reg;   // keys seen so far this scan, saturates at 2
  logic [4:0]       hit_code_reg;
  logic             dwell_end;
  logic             scan_end;
  logic [2:0]       row_pop;
  logic [2:0]       hit_col;
  logic [2:0]       hit_sum;
  logic [1:0]       hit_cnt_next;
  logic [4:0]       hit_code_next;
  scan_result_t     scan_res;

  scan_state_t      state_reg;
  logic [4:0]       cand_reg;
  logic [7:0]       cnt_reg;
  logic [7:0]       cnt_inc;
  logic [4:0]       keycode_reg;
  logic             keyheld_reg;
  logic             fire_reg;
  logic             newkey_reg;

  keypad_sync #(.WIDTH(5), .RESET_VAL(5'h1F)) u_col_sync (
    .clock (clock),
    .reset (reset),
    .d     (col),
    .q     (col_sync)
  );

  assign dwell_end = (div_cnt_reg == DIV_LAST);
  assign scan_end  = dwell_end && (row_idx_reg == 2'd3);

  // Count active columns in the current row and remember the last one.
  always_comb begin
    row_pop = 3'd0;
    hit_col = 3'd0;
    for (int i = 0; i < 5; i++) begin
      if (!col_sync[i]) begin
        row_pop = row_pop + 3'd1;
        hit_col = 3'(i);
      end
    end
  end

  // Fold this row's sample into the running scan tally. The code is only
  // meaningful when the whole scan ends with exactly one key.
  always_comb begin
    hit_sum       = {1'b0, hit_cnt_reg} + row_pop;
    hit_cnt_next  = (hit_sum >= 3'd2) ? 2'd2 : hit_sum[1:0];
    hit_code_next = hit_code_reg;
    if (hit_cnt_reg == 2'd0 && row_pop == 3'd1) begin
      hit_code_next = key_code(row_idx_reg, hit_col);
    end
    case (hit_cnt_next)
      2'd0:    scan_res = SCAN_NONE;
      2'd1:    scan_res = SCAN_ONE;
      default: scan_res = SCAN_MULTI;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      div_cnt_reg  <= '0;
      row_idx_reg  <= 2'd0;
      row_reg      <= 4'b1110;
      hit_cnt_reg  <= 2'd0;
      hit_code_reg <= KEY_NULL;
    end else if (dwell_end) begin
      div_cnt_reg <= '0;
      row_idx_reg <= row_idx_reg + 2'd1;
      row_reg     <= {row_reg[2:0], row_reg[3]};
      if (scan_end) begin
        hit_cnt_reg  <= 2'd0;
        hit_code_reg <= KEY_NULL;
      end else begin
        hit_cnt_reg  <= hit_cnt_next;
        hit_code_reg <= hit_code_next;
      end
    end else begin
      div_cnt_reg <= div_cnt_reg + 1'b1;
    end
  end

  assign cnt_inc = cnt_reg + 8'd1;

  // Debounce FSM, advanced only on the last clock of a full scan. The
  // acceptance edge loads keycode; newKey follows one clock later so the
  // code is already stable when the pulse appears.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg   <= ST_IDLE;
      cand_reg    <= KEY_NULL;
      cnt_reg     <= 8'd0;
      keycode_reg <= KEY_NULL;
      keyheld_reg <= 1'b0;
      fire_reg    <= 1'b0;
      newkey_reg  <= 1'b0;
    end else begin
      newkey_reg <= fire_reg;
      fire_reg   <= 1'b0;
      if (scan_end) begin
        case (state_reg)
          ST_IDLE: begin
            if (scan_res == SCAN_ONE) begin
              cand_reg <= hit_code_next;
              cnt_reg  <= 8'd1;
              if (DB_TARGET == 8'd1) begin
                state_reg   <= ST_PRESSED;
                keycode_reg <= hit_code_next;
                keyheld_reg <= 1'b1;
                fire_reg    <= 1'b1;
              end else begin
                state_reg <= ST_DB_PRESS;
              end
            end
          end
          ST_DB_PRESS: begin
            if (scan_res == SCAN_ONE && hit_code_next == cand_reg) begin
              cnt_reg <= cnt_inc;
              if (cnt_inc == DB_TARGET) begin
                state_reg   <= ST_PRESSED;
                keycode_reg <= cand_reg;
                keyheld_reg <= 1'b1;
                fire_reg    <= 1'b1;
              end
            end else if (scan_res == SCAN_ONE) begin
              cand_reg <= hit_code_next;
              cnt_reg  <= 8'd1;
            end else begin
              state_reg <= ST_IDLE;
              cnt_reg   <= 8'd0;
            end
          end
          ST_PRESSED: begin
            if (scan_res == SCAN_NONE) begin
              cnt_reg <= 8'd1;
              if (DB_TARGET == 8'd1) begin
                state_reg   <= ST_IDLE;
                keycode_reg <= KEY_NULL;
                keyheld_reg <= 1'b0;
              end else begin
                state_reg <= ST_DB_RELEASE;
              end
            end
          end
          ST_DB_RELEASE: begin
            if (scan_res == SCAN_NONE) begin
              cnt_reg <= cnt_inc;
              if (cnt_inc == DB_TARGET) begin
                state_reg   <= ST_IDLE;
                cnt_reg     <= 8'd0;
                keycode_reg <= KEY_NULL;
                keyheld_reg <= 1'b0;
              end
            end else begin
              // Release bounce: back to held without a new pulse.
              state_reg <= ST_PRESSED;
              cnt_reg   <= 8'd0;
            end
          end
          default: state_reg <= ST_IDLE;
        endcase
      end
    end
  end

  assign row     = row_reg;
  assign newKey  = newkey_reg;
  assign keycode = keycode_reg;
  assign keyHeld = keyheld_reg;

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: directed keypad scenarios with a newKey scoreboard.
// Stimulus pushes the keycode each press should produce; a monitor pops it
// whenever newKey pulses. A pulse with nothing queued is an error, and each
// phase checks that every queued press was seen.
module tb_keypad_scanner;
  import calc_keys_pkg::*;

  logic        clock;
  logic        reset;
  logic [3:0]  row;
  logic [4:0]  col;
  logic        newKey;
  logic [4:0]  keycode;
  logic        keyHeld;

  logic [19:0] keys;          // bit r*5+c set = key (r,c) held down
  logic [4:0]  exp_q[$];
  logic [4:0]  prev_keycode;
  int          checks = 0;
  int          errors = 0;

  keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_SCANS(3)) dut (
    .clock   (clock),
    .reset   (reset),
    .row     (row),
    .col     (col),
    .newKey  (newKey),
    .keycode (keycode),
    .keyHeld (keyHeld)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Passive matrix: a held key pulls its column low while its row is driven.
  always_comb begin
    col = 5'h1F;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 5; c++) begin
        if (!row[r] && keys[r*5+c]) col[c] = 1'b0;
      end
    end
  end

  // Monitor: every newKey pulse must match the next queued press, and the
  // keycode must already have been stable on the clock before the pulse.
  always @(negedge clock) begin
    if (reset) begin
      if (newKey) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_newkey: got keycode=%h, required no pulse", keycode);
        end else begin
          logic [4:0] exp_code;
          exp_code = exp_q.pop_front();
          $display("newKey keycode=%h expected=%h keyHeld=%0b", keycode, exp_code, keyHeld);
          checks++;
          if (keycode !== exp_code || keyHeld !== 1'b1) begin
            errors++;
            $display("FAIL pulse_code: got keycode=%h keyHeld=%0b, required keycode=%h keyHeld=1",
                     keycode, keyHeld, exp_code);
          end
          checks++;
          if (prev_keycode !== exp_code) begin
            errors++;
            $display("FAIL keycode_setup: got %h one clock before pulse, required %h",
                     prev_keycode, exp_code);
          end
        end
      end
      prev_keycode = keycode;
    end else begin
      prev_keycode = KEY_NULL;
    end
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic wait_clocks(input int n);
    repeat (n) @(negedge clock);
  endtask

  // Return on the first falling edge of a fresh row-0 dwell (scan start).
  task automatic wait_scan_start();
    int guard = 0;
    while (row == 4'b1110 && guard < 64) begin
      @(negedge clock);
      guard++;
    end
    while (row != 4'b1110 && guard < 64) begin
      @(negedge clock);
      guard++;
    end
    if (guard >= 64) begin
      checks++;
      errors++;
      $display("FAIL scan_align: timeout, row=%b, required 1110", row);
    end
  endtask

  task automatic expect_done(input string name);
    check(name, 8'(exp_q.size()), 8'd0);
    exp_q.delete();
  endtask

  task automatic press(input int r, input int c);
    keys[r*5+c] = 1'b1;
  endtask

  task automatic unpress(input int r, input int c);
    keys[r*5+c] = 1'b0;
  endtask

  task automatic check_idle(input string name);
    check({name, "_held"}, 8'(keyHeld), 8'd0);
    check({name, "_code"}, 8'(keycode), 8'(KEY_NULL));
  endtask

  initial begin
    keys  = '0;
    reset = 1'b0;
    wait_clocks(3);
    check("reset_row", 8'(row), 8'h0E);
    check("reset_newkey", 8'(newKey), 8'd0);
    check_idle("reset");
    reset = 1'b1;
    wait_clocks(5);

    // 1: digit 7 held steady, then released.
    $display("phase 1: hold 7");
    exp_q.push_back(5'h17);
    press(1, 3);
    wait_clocks(100);
    expect_done("p1_pulse");
    check("p1_held", 8'(keyHeld), 8'd1);
    check("p1_code", 8'(keycode), 8'h17);
    keys = '0;
    wait_clocks(80);
    check_idle("p1_release");

    // 2: EQUAL held 2 scans, dropped 1 scan, then held steady.
    $display("phase 2: EQUAL with gap");
    wait_scan_start();
    press(3, 4);
    wait_clocks(32);
    keys = '0;
    wait_clocks(16);
    check("p2_no_accept", 8'(keyHeld), 8'd0);
    press(3, 4);
    exp_q.push_back(KEY_EQUAL);
    wait_clocks(100);
    expect_done("p2_pulse");
    check("p2_code", 8'(keycode), 8'(KEY_EQUAL));
    keys = '0;
    wait_clocks(80);
    check_idle("p2_release");

    // 3: 1, 2, PLUS in sequence.
    $display("phase 3: 1, 2, PLUS");
    exp_q.push_back(5'h11);
    press(0, 1);
    wait_clocks(100);
    keys = '0;
    wait_clocks(80);
    exp_q.push_back(5'h12);
    press(0, 2);
    wait_clocks(100);
    keys = '0;
    wait_clocks(80);
    exp_q.push_back(KEY_PLUS);
    press(1, 4);
    wait_clocks(100);
    expect_done("p3_pulses");
    check("p3_code", 8'(keycode), 8'(KEY_PLUS));
    keys = '0;
    wait_clocks(80);
    check_idle("p3_release");

    // 4: A and B together is rejected; dropping B accepts A.
    $display("phase 4: A+B then A");
    press(2, 2);
    press(2, 3);
    wait_clocks(100);
    check("p4_multi_held", 8'(keyHeld), 8'd0);
    exp_q.push_back(5'h1A);
    unpress(2, 3);
    wait_clocks(100);
    expect_done("p4_pulse");
    check("p4_code", 8'(keycode), 8'h1A);
    keys = '0;
    wait_clocks(80);
    check_idle("p4_release");

    // 5: C held, F added, both released with a one-scan C bounce.
    $display("phase 5: C, add F, bounce on release");
    exp_q.push_back(5'h1C);
    press(3, 0);
    wait_clocks(100);
    press(3, 3);
    wait_clocks(50);
    check("p5_code_with_f", 8'(keycode), 8'h1C);
    wait_scan_start();
    keys = '0;
    wait_clocks(16);
    press(3, 0);
    wait_clocks(16);
    keys = '0;
    check("p5_bounce_held", 8'(keyHeld), 8'd1);
    check("p5_bounce_code", 8'(keycode), 8'h1C);
    wait_clocks(100);
    expect_done("p5_pulse");
    check_idle("p5_release");

    // 6: reset during press debounce, key still held afterwards.
    $display("phase 6: reset mid DB_PRESS");
    wait_scan_start();
    press(1, 1);
    wait_clocks(40);
    #3 reset = 1'b0;
    #1;
    check("p6_row", 8'(row), 8'h0E);
    check("p6_newkey", 8'(newKey), 8'd0);
    check_idle("p6_reset");
    wait_clocks(3);
    reset = 1'b1;
    exp_q.push_back(5'h15);
    wait_clocks(100);
    expect_done("p6_pulse");
    check("p6_code", 8'(keycode), 8'h15);
    keys = '0;
    wait_clocks(80);
    check_idle("p6_release");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
